// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one 32-bit ALU. Round-robin grant, then a
// fixed IDLE -> EXEC -> DONE sequence per operation.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        err,
  output logic        busy,
  output logic [15:0] op_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e      state_q, state_d;
  logic        id_q, id_d;
  logic        last_id_q, last_id_d;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [15:0] op_cnt_q, op_cnt_d;
  logic        any_req;
  logic        win_id;
  logic [32:0] alu_out;

  // Returns {unsupported, value}. The compares are unsigned; only opcode A
  // treats b as signed.
  function automatic logic [32:0] alu_f(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sb;
    logic [32:0]        r;
    sb = b;
    r  = {1'b0, 32'h0};
    case (op)
      4'h0: r = {1'b0, ~a};
      4'h1: r = {1'b0, ~b};
      4'h2: r = {1'b0, a & b};
      4'h3: r = {1'b0, a | b};
      4'h4: r = {1'b0, a ^ b};
      4'h5: r = {1'b0, ~(a ^ b)};
      4'h6: r = {1'b0, 31'h0, (a < b)};
      4'h7: r = {1'b0, 31'h0, (a > b)};
      4'h8: r = {1'b0, b << 1};
      4'h9: r = {1'b0, b >> 1};
      4'hA: r = {1'b0, sb >>> 1};
      4'hB: r = {1'b0, a + b};
      4'hC: r = {1'b0, a - b};
      default: r = {1'b1, 32'h0};
    endcase
    return r;
  endfunction

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) win_id = ~last_id_q;
    else              win_id = req1;
  end

  assign alu_out = alu_f(op_q, a_q, b_q);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    result_d  = result_q;
    err_d     = err_q;
    op_cnt_d  = op_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = EXEC;
          id_d      = win_id;
          last_id_d = win_id;
        end
      end
      EXEC: begin
        state_d  = DONE;
        err_d    = alu_out[32];
        result_d = alu_out[31:0];
      end
      DONE: begin
        state_d  = IDLE;
        op_cnt_d = op_cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      result_q  <= 32'h0;
      err_q     <= 1'b0;
      op_cnt_q  <= 16'h0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      result_q  <= result_d;
      err_q     <= err_d;
      op_cnt_q  <= op_cnt_d;
    end
  end

  // Operand latch: captured only on the IDLE->EXEC edge, so the ALU never
  // sees requester inputs directly.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && any_req) begin
      op_q <= win_id ? op1 : op0;
      a_q  <= win_id ? a1  : a0;
      b_q  <= win_id ? b1  : b0;
    end
  end

  assign gnt0   = (state_q == EXEC) && !id_q;
  assign gnt1   = (state_q == EXEC) &&  id_q;
  assign done0  = (state_q == DONE) && !id_q;
  assign done1  = (state_q == DONE) &&  id_q;
  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign err    = err_q;
  assign op_cnt = op_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, randomized
// operations against a plain-arithmetic model, and tie/reset sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1, err, busy;
  logic [31:0] result;
  logic [15:0] op_cnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  alu_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err), .busy(busy), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: opcode semantics in plain integer arithmetic.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint la, lb, t;
    la = longint'(a);
    lb = longint'(b);
    t  = 0;
    case (op)
      4'h0: t = 64'hFFFFFFFF - la;
      4'h1: t = 64'hFFFFFFFF - lb;
      4'h2: t = longint'(a & b);
      4'h3: t = longint'(a | b);
      4'h4: t = longint'(a ^ b);
      4'h5: t = 64'hFFFFFFFF - longint'(a ^ b);
      4'h6: t = (la < lb) ? 1 : 0;
      4'h7: t = (la > lb) ? 1 : 0;
      4'h8: t = lb * 2;
      4'h9: t = lb / 2;
      4'hA: t = lb / 2 + ((lb >= 64'h80000000) ? 64'h80000000 : 0);
      4'hB: t = la + lb;
      4'hC: t = la - lb + 64'h100000000;
      default: return {1'b1, 32'h0};
    endcase
    t = t % 64'h100000000;
    return {1'b0, t[31:0]};
  endfunction

  task automatic do_op(input bit id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] xres, input bit xerr,
                       input string tag);
    if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    @(posedge clk); #1;
    chk({tag, "_gnt"}, 32'({gnt1, gnt0}), id ? 32'd2 : 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done"}, 32'({done1, done0}), id ? 32'd2 : 32'd1);
    chk({tag, "_result"}, result, xres);
    chk({tag, "_err"}, 32'(err), 32'(xerr));
    @(posedge clk); #1;
    exp_cnt = (exp_cnt + 1) % 65536;
    chk({tag, "_opcnt"}, 32'(op_cnt), 32'(exp_cnt));
    chk({tag, "_idle"}, 32'({busy, done1, done0, gnt1, gnt0}), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{0, 4'hB, 32'd5,        32'd7,        32'h0000000C, 0};
    vecs[1]  = '{1, 4'hC, 32'd3,        32'd5,        32'hFFFFFFFE, 0};
    vecs[2]  = '{0, 4'h8, 32'h0,        32'h80000001, 32'h00000002, 0};
    vecs[3]  = '{0, 4'hA, 32'h0,        32'h80000000, 32'hC0000000, 0};
    vecs[4]  = '{1, 4'hE, 32'h1234,     32'h5678,     32'h00000000, 1};
    vecs[5]  = '{0, 4'h0, 32'h0,        32'h0,        32'hFFFFFFFF, 0};
    vecs[6]  = '{1, 4'h6, 32'd3,        32'd5,        32'h00000001, 0};
    vecs[7]  = '{1, 4'h7, 32'd3,        32'd5,        32'h00000000, 0};
    vecs[8]  = '{0, 4'h9, 32'h0,        32'h80000001, 32'h40000000, 0};
    vecs[9]  = '{0, 4'h5, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 0};
    vecs[10] = '{1, 4'hB, 32'hFFFFFFFF, 32'h1,        32'h00000000, 0};
    vecs[11] = '{0, 4'hF, 32'h1,        32'h1,        32'h00000000, 1};
    vecs[12] = '{1, 4'h2, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0};
    vecs[13] = '{0, 4'h6, 32'h80000000, 32'h1,        32'h00000000, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", 32'({busy, err, done1, done0, gnt1, gnt0}), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_opcnt", 32'(op_cnt), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      do_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err,
            $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      logic [32:0] m;
      bit          rid;
      rid = 1'($urandom_range(0, 1));
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 5 == 0) rb = ra;
      m = model(rop, ra, rb);
      do_op(rid, rop, ra, rb, m[31:0], m[32], $sformatf("rnd%0d", i));
    end

    // Abort in EXEC: outputs drop asynchronously and the op is not counted.
    req0 = 1'b1; op0 = 4'hB; a0 = 32'd9; b0 = 32'd9;
    @(posedge clk); #1;
    chk("abort_gnt", 32'({gnt1, gnt0}), 32'd1);
    req0 = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'h0);
    chk("abort_opcnt", 32'(op_cnt), 32'd0);
    chk("abort_pulses", 32'({err, done1, done0, gnt1, gnt0}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_cnt = 0;
    begin
      int seen_done;
      seen_done = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (done0 || done1) seen_done++;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);
      chk("abort_opcnt_after", 32'(op_cnt), 32'd0);
    end

    // Tie after reset: requester 0 first, requester 1 three cycles later.
    req0 = 1'b1; op0 = 4'hB; a0 = 32'd1; b0 = 32'd1;
    req1 = 1'b1; op1 = 4'h4; a1 = 32'hA; b1 = 32'h5;
    @(posedge clk); #1;
    chk("tie1_gnt", 32'({gnt1, gnt0}), 32'd1);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("tie1_done", 32'({done1, done0}), 32'd1);
    chk("tie1_result", result, 32'd2);
    @(posedge clk); #1;
    chk("tie_idle_gap", 32'({busy, gnt1, gnt0}), 32'd0);
    begin
      int waited;
      waited = 0;
      while (!gnt1 && waited < 5) begin
        @(posedge clk); #1;
        waited++;
      end
      chk("tie2_gnt_cycle", 32'(waited), 32'd1);
    end
    chk("tie2_gnt", 32'({gnt1, gnt0}), 32'd2);
    req1 = 1'b0;
    @(posedge clk); #1;
    chk("tie2_done", 32'({done1, done0}), 32'd2);
    chk("tie2_result", result, 32'hF);
    @(posedge clk); #1;
    chk("tie2_opcnt", 32'(op_cnt), 32'd2);
    req0 = 1'b1; req1 = 1'b1;
    op0 = 4'h3; a0 = 32'h10; b0 = 32'h01;
    @(posedge clk); #1;
    chk("tie3_gnt", 32'({gnt1, gnt0}), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    chk("tie3_result", result, 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
